// File: rtl/pdm_mic_ctrl.sv
// PDM microphone controller: generates the mic clock, sequences wake/settle/run,
// samples the selected channel edge for the CIC and gates its PCM output.
module pdm_mic_ctrl #(
  parameter int CLK_DIV        = 16,
  parameter int WAKE_PERIODS   = 1024,
  parameter int SETTLE_SAMPLES = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int OUT_BITS       = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                chan_sel,
  input  logic                pdm_data,
  output logic                pdm_clk,
  output logic                pdm_bit,
  output logic                pdm_valid,
  output logic                cic_clear,
  input  logic [OUT_BITS-1:0] cic_pcm,
  input  logic                cic_pcm_valid,
  output logic [OUT_BITS-1:0] pcm_out,
  output logic                pcm_valid,
  output logic                running,
  output logic [2:0]          state_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAKE   = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int WAKE_W = (WAKE_PERIODS > 0) ? $clog2(WAKE_PERIODS + 1) : 1;
  localparam int SET_W  = (SETTLE_SAMPLES > 0) ? $clog2(SETTLE_SAMPLES + 1) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(CLK_DIV / 2);
  localparam logic [DIV_W-1:0]  HALF_LAST = DIV_W'(CLK_DIV / 2 - 1);
  localparam logic [DIV_W-1:0]  SP_LEFT   = DIV_W'(CLK_DIV / 2 - 1 + SYNC_STAGES);
  localparam logic [DIV_W-1:0]  SP_RIGHT  = DIV_W'((CLK_DIV - 1 + SYNC_STAGES) % CLK_DIV);
  localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_PERIODS - 1);
  localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETTLE_SAMPLES - 1);

  logic [2:0]             state, state_nxt;
  logic [DIV_W-1:0]       div_cnt, div_nxt;
  logic [WAKE_W-1:0]      wake_cnt;
  logic [SET_W-1:0]       settle_cnt;
  logic [SYNC_STAGES-1:0] sync_q, sync_nxt;
  logic                   chan_lat;
  logic                   clk_nxt;
  logic                   strobe_nxt;
  logic [DIV_W-1:0]       sample_pt;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (enable) state_nxt = S_WAKE;
      S_WAKE: begin
        if (!enable) state_nxt = S_STOP;
        else if (div_cnt == DIV_LAST && wake_cnt == WAKE_LAST) state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        if (!enable) state_nxt = S_STOP;
        else if (SETTLE_SAMPLES == 0) state_nxt = S_RUN;
        else if (cic_pcm_valid && settle_cnt == SET_LAST) state_nxt = S_RUN;
      end
      S_RUN:    if (!enable) state_nxt = S_STOP;
      // Leave only at the end of a high phase or while low, so no runt high pulse.
      S_STOP:   if (div_cnt == HALF_LAST || !pdm_clk) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase

    if (state == S_IDLE || state_nxt == S_IDLE) div_nxt = '0;
    else if (div_cnt == DIV_LAST)               div_nxt = '0;
    else                                        div_nxt = div_cnt + 1'b1;

    clk_nxt    = (state_nxt != S_IDLE) && (div_nxt < DIV_HALF);
    sample_pt  = chan_lat ? SP_RIGHT : SP_LEFT;
    strobe_nxt = (state_nxt == S_SETTLE || state_nxt == S_RUN) && (div_nxt == sample_pt);

    sync_nxt    = '0;
    sync_nxt[0] = pdm_data;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_nxt[i] = sync_q[i-1];
  end

  // Outputs are loaded from next-state values so they line up with div_cnt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      div_cnt    <= '0;
      wake_cnt   <= '0;
      settle_cnt <= '0;
      sync_q     <= '0;
      chan_lat   <= 1'b0;
      pdm_clk    <= 1'b0;
      pdm_bit    <= 1'b0;
      pdm_valid  <= 1'b0;
      pcm_out    <= '0;
      pcm_valid  <= 1'b0;
    end else begin
      state     <= state_nxt;
      div_cnt   <= div_nxt;
      sync_q    <= sync_nxt;
      pdm_clk   <= clk_nxt;
      pdm_valid <= strobe_nxt;
      if (strobe_nxt) pdm_bit <= sync_nxt[SYNC_STAGES-1];
      if (state == S_IDLE && enable) chan_lat <= chan_sel;

      if (state != S_WAKE)           wake_cnt <= '0;
      else if (div_cnt == DIV_LAST)  wake_cnt <= wake_cnt + 1'b1;

      if (state != S_SETTLE)         settle_cnt <= '0;
      else if (cic_pcm_valid)        settle_cnt <= settle_cnt + 1'b1;

      pcm_valid <= (state == S_RUN) && cic_pcm_valid;
      if (state == S_RUN && cic_pcm_valid) pcm_out <= cic_pcm;
    end
  end

  assign cic_clear = !(state == S_SETTLE || state == S_RUN);
  assign running   = (state == S_RUN);
  assign state_o   = state;

endmodule
